prob_mul_node_acc: RTL
======================

# prob_mul_node_acc

Parametrised streaming product node for the probabilistic-circuit datapath. It succeeds the fixed-width multiply tree. Each cycle it accepts one line of `LANES` unsigned custom-float probabilities and multiplies each lane into a per-lane accumulator over a run-time-programmable number of lines. It then emits the node result on a valid/ready output port and tracks the maximum result exponent for the downstream rescaler.

## Interface
- `LANES`, 4: channels per line.
- `EW`, 8: exponent width.
- `MW`, 8: mantissa width (hidden leading 1).
- `BIAS`, 127: exponent bias.
- `LEN_W`, 11: width of the run-time line-count field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mode` in 2: 00 accumulate, 01 pass-through, 10/11 reserved (behave as 00).
- `node_len_m1` in LEN_W: lines per node minus one; sampled on the first accepted beat of a node.
- `interface_in` in LANES*(EW+MW): lane k occupies bits [k*(EW+MW) +: EW+MW], `{exp, man}`.
- `input_vld` in 1: input beat valid.
- `input_ready` out 1: block can accept a beat.
- `interface_out` out LANES*(EW+MW): node result, same packing as the input.
- `output_vld` out 1: result valid.
- `output_ready` in 1: downstream accepts the result.
- `max_exponent` out EW: maximum lane exponent over results emitted since the last read.
- `max_exponent_vld` out 1: at least one result was emitted since the last read.
- `max_exponent_ready` in 1: consumer reads `max_exponent`.

## Operation
- Number format: exp=0 encodes zero, ignoring the mantissa. Otherwise the value is 1.man × 2^(exp−BIAS).
- Lane multiply (combinational):
  - If either operand is zero, the result is zero (0x0…0).
  - p = {1,ma}·{1,mb}, 2MW+2 bits.
  - If p[2MW+1] is set: man = p[2MW:MW+1] and e = ea+eb−BIAS+1. Otherwise: man = p[2MW−1:MW] and e = ea+eb−BIAS.
  - The mantissa is truncated, with no rounding.
  - Compute e signed at EW+2 bits.
  - If e ≤ 0, flush the result to zero.
  - If e ≥ 2^EW−1, saturate to exp = 2^EW−2 and man = all ones.
- Accumulator: one register per lane. Its start value is 1.0 (exp=BIAS, man=0).
- FSM states:
  - **IDLE**: waits for the first beat of a node.
  - **ACC**: accepts the remaining beats of the node.
  - **HOLD**: holds the result until it is taken.
- FSM transitions:
  - IDLE → ACC, on the first accepted beat:
    - Sample `node_len_m1` into `len_q`.
    - acc ← 1.0 × in, i.e. the lane value after flush/saturate checks.
    - Set cnt ← 0.
    - If len_q = 0, go to HOLD instead of ACC.
  - ACC, per accepted beat:
    - acc ← acc × in.
    - cnt ← cnt+1.
    - When cnt+1 = len_q, go to HOLD.
  - HOLD: `output_vld`=1 and `interface_out`=acc. On `output_ready`, go to IDLE.
- Mode 01: every node is one line, regardless of `node_len_m1`.
- Mode changes take effect only when the block is in IDLE. `mode` is sampled together with `node_len_m1`.
- `input_ready` = (state ≠ HOLD). There is no input accepted while a result is pending.
- Max exponent tracker:
  - On each output handshake, mx ← max(mx, max lane exp of the result) and set `max_exponent_vld`=1.
  - On a `max_exponent_ready` && `max_exponent_vld` handshake, clear mx to 0 and `max_exponent_vld` to 0.
  - If an output handshake coincides with a read, mx takes the new result's max only; the old value is consumed and `max_exponent_vld` stays 1.

## Timing
- Reset values:
  - State IDLE.
  - `input_ready`=1.
  - `output_vld`=0.
  - `interface_out`=0.
  - `max_exponent`=0.
  - `max_exponent_vld`=0.
  - acc = 1.0, cnt = 0.
- Reset asserted mid-node discards the partial accumulator and any pending result.
- Beat acceptance = `input_vld` && `input_ready`. The product is registered at that edge.
- Latency: `output_vld` rises in the cycle after the last beat of the node is accepted. Pass-through latency is 1 cycle.
- Throughput:
  - 1 line/cycle inside a node.
  - One bubble cycle (HOLD) per node when `output_ready` is already high. Node-to-node throughput is N lines per N+1 cycles.
- `interface_out` is stable while `output_vld`=1 and `output_ready`=0.
- Gaps with `input_vld`=0 inside a node stall the count and do not advance it.
- `max_exponent`/`max_exponent_vld` update the cycle after the handshake.
- Maximum node length is 2^LEN_W lines. The counter never wraps.

## Test plan
- **Reset**: `rst`=0 asynchronously mid-ACC → all outputs take their reset values immediately. After release, a 1-line node of 0x7E00 in every lane → `interface_out`=0x7E00_7E00_7E00_7E00.
- **Accumulate**: `node_len_m1`=1, lanes {0.5, 0.75} × {0.5, 0.75} (0x7E00, 0x7E80) → lane results 0x7D00 (0.25) and 0x7E20 (0.5625). `output_vld` rises one cycle after the second beat.
- **Zero and underflow**: lane 0 = 0x0000 × 0x7E00, lane 1 = 0x0100 × 0x0100 → both lanes yield 0x0000.
- **Backpressure**: hold `output_ready`=0 for 5 cycles in HOLD → `input_ready`=0, `interface_out` stable. Release → the next node starts in the following cycle.
- **Pass-through**: `mode`=01, `node_len_m1`=7, 8 lines streamed → 8 results, each equal to its input line. The inputs are the lane values after flush/saturate checks.
- **Max exponent**: emit results with max exp 0x7D then 0x7E, then assert `max_exponent_ready` → reads 0x7E and `max_exponent_vld` clears. Output and read in the same cycle → `max_exponent_vld` stays 1 and holds only the new result's max.

Source files
------------

// File: rtl/prob_mul_node_acc.sv
// Streaming product node: multiplies LANES custom-float lanes into per-lane accumulators
// over a programmable number of lines, emits the result on valid/ready and tracks its max exponent.
module prob_mul_node_acc #(
    parameter int unsigned LANES = 4,
    parameter int unsigned EW    = 8,
    parameter int unsigned MW    = 8,
    parameter int unsigned BIAS  = 127,
    parameter int unsigned LEN_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic [LEN_W-1:0]           node_len_m1,
    input  logic [LANES*(EW+MW)-1:0]   interface_in,
    input  logic                       input_vld,
    output logic                       input_ready,
    output logic [LANES*(EW+MW)-1:0]   interface_out,
    output logic                       output_vld,
    input  logic                       output_ready,
    output logic [EW-1:0]              max_exponent,
    output logic                       max_exponent_vld,
    input  logic                       max_exponent_ready
);

    localparam int unsigned FW = EW + MW;
    localparam logic [FW-1:0] ONE     = {EW'(BIAS), {MW{1'b0}}};
    localparam logic [FW-1:0] SAT_VAL = {{(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
    localparam logic [EW:0]   E_SAT   = {1'b0, {EW{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [LANES*FW-1:0]    acc_q, prod;
    logic [LEN_W-1:0]       cnt_q, len_q, eff_len;
    logic [LEN_W:0]         cnt_inc;
    logic [EW-1:0]          res_max, mx_q;
    logic                   mx_vld_q, accept, out_hs, rd_hs;

    function automatic logic [FW-1:0] fmul(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [EW-1:0]     ea, eb;
        logic [MW-1:0]     ma, mb, man;
        logic [2*MW+1:0]   p;
        logic [EW+1:0]     e;
        logic [FW-1:0]     r;
        ea  = a[FW-1:MW];
        eb  = b[FW-1:MW];
        ma  = a[MW-1:0];
        mb  = b[MW-1:0];
        p   = (2*MW+2)'({1'b1, ma}) * (2*MW+2)'({1'b1, mb});
        man = p[2*MW+1] ? p[2*MW:MW+1] : p[2*MW-1:MW];
        // Signed exponent held in two's complement; bit EW+1 is the sign.
        e   = {2'b00, ea} + {2'b00, eb} - (EW+2)'(BIAS) + {{(EW+1){1'b0}}, p[2*MW+1]};
        if (ea == '0 || eb == '0 || e[EW+1] || e == '0)
            r = '0;
        else if (e[EW:0] >= E_SAT)
            r = SAT_VAL;
        else
            r = {e[EW-1:0], man};
        return r;
    endfunction

    assign accept      = input_vld && input_ready;
    assign out_hs      = output_vld && output_ready;
    assign rd_hs       = max_exponent_ready && mx_vld_q;
    assign eff_len     = (mode == 2'b01) ? '0 : node_len_m1;
    assign cnt_inc     = {1'b0, cnt_q} + (LEN_W+1)'(1);

    assign input_ready      = (state_q != S_HOLD);
    assign output_vld       = (state_q == S_HOLD);
    assign interface_out    = (state_q == S_HOLD) ? acc_q : '0;
    assign max_exponent     = mx_q;
    assign max_exponent_vld = mx_vld_q;

    // In IDLE the first beat is multiplied by 1.0 so it passes through the same flush/saturate path.
    always_comb begin
        prod    = '0;
        res_max = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            prod[k*FW +: FW] = fmul((state_q == S_IDLE) ? ONE : acc_q[k*FW +: FW],
                                    interface_in[k*FW +: FW]);
            if (acc_q[k*FW+MW +: EW] > res_max)
                res_max = acc_q[k*FW+MW +: EW];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (eff_len == '0) ? S_HOLD : S_ACC;
            S_ACC:  if (accept && cnt_inc == {1'b0, len_q}) state_d = S_HOLD;
            S_HOLD: if (output_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= {LANES{ONE}};
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= prod;
                if (state_q == S_IDLE) begin
                    len_q <= eff_len;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_inc[LEN_W-1:0];
                end
            end
        end
    end

    // A read coinciding with a new result consumes the old max, keeping only the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx_q     <= '0;
            mx_vld_q <= 1'b0;
        end else if (out_hs) begin
            mx_q     <= (rd_hs || res_max > mx_q) ? res_max : mx_q;
            mx_vld_q <= 1'b1;
        end else if (rd_hs) begin
            mx_q     <= '0;
            mx_vld_q <= 1'b0;
        end
    end

endmodule
